// File: rtl/fetch_unit_pkg.sv
// Shared constants for the nemesys fetch stage: instruction width, opcode
// field bounds, opcode codes and the fetch state encoding.
package fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  // Opcode field sits in the top five bits of every instruction word
  localparam int unsigned OP_W   = 5;
  localparam int unsigned OP_MSB = INST_W - 1;
  localparam int unsigned OP_LSB = INST_W - OP_W;

  localparam logic [OP_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OP_W-1:0] OP_MOV  = 5'h01;
  localparam logic [OP_W-1:0] OP_ADD  = 5'h02;
  localparam logic [OP_W-1:0] OP_SUB  = 5'h03;
  localparam logic [OP_W-1:0] OP_LD   = 5'h04;
  localparam logic [OP_W-1:0] OP_ST   = 5'h05;
  localparam logic [OP_W-1:0] OP_BR   = 5'h06;
  localparam logic [OP_W-1:0] OP_JMP  = 5'h07;
  localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

  typedef enum logic [1:0] {
    FS_RUN       = 2'd0,
    FS_HALT_WAIT = 2'd1,
    FS_HALTED    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode.
// Ports: clk, rst_n (sync, active-low); push/push_pc/push_inst write the tail;
// pop advances the head; flush empties the queue and wins over push;
// head_valid/head_pc/head_inst present the oldest entry; count is occupancy.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic [WIDTH-1:0]         push_inst,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [31:0]              head_pc,
  output logic [WIDTH-1:0]         head_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      mem_pc   [DEPTH];
  logic [WIDTH-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;

  // Storage is reset so the head reads as zero straight out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_pc[wptr]   <= push_pc;
        mem_inst[wptr] <= push_inst;
        wptr           <= PTR_W'(wptr + PTR_W'(1));
      end
      if (pop) begin
        rptr <= PTR_W'(rptr + PTR_W'(1));
      end
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

  // Head is a mux over flops only; no input feeds it combinationally
  assign head_valid = (count != '0);
  assign head_pc    = mem_pc[rptr];
  assign head_inst  = mem_inst[rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory, queues {pc, inst} for the decoder and stops after fetching HALT.
// Ports: clk, rst_n (sync, active-low); pc/inst to instruction memory;
// redirect_valid/redirect_target from execute; dec_valid/dec_inst/dec_pc/
// dec_ready handshake to decode; halted is sticky until reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = INST_W,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      pc,
  input  logic [WIDTH-1:0] inst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             dec_valid,
  output logic [WIDTH-1:0] dec_inst,
  output logic [31:0]      dec_pc,
  input  logic             dec_ready,
  output logic             halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             flush;
  logic             fetched_halt;

  assign pop          = dec_valid && dec_ready;
  // A redirect blocks the push: the word at the old pc is on the wrong path
  assign push         = (state == FS_RUN) && !redirect_valid &&
                        ((count != CNT_W'(DEPTH)) || pop);
  assign flush        = redirect_valid && (state != FS_HALTED);
  assign fetched_halt = (inst[WIDTH-1 -: OP_W] == OP_HALT);

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (pc),
    .push_inst  (inst),
    .pop        (pop),
    .flush      (flush),
    .head_valid (dec_valid),
    .head_pc    (dec_pc),
    .head_inst  (dec_inst),
    .count      (count)
  );

  // PC and fetch state machine; redirect takes priority over push and HALT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      state  <= FS_RUN;
      halted <= 1'b0;
    end else if (flush) begin
      pc    <= redirect_target;
      state <= FS_RUN;
    end else begin
      case (state)
        FS_RUN: begin
          if (push) begin
            if (fetched_halt) state <= FS_HALT_WAIT;
            else              pc    <= 32'(pc + 32'd1);
          end
        end
        FS_HALT_WAIT: begin
          // Nothing is pushed behind HALT, so it is the last entry left
          if (pop && (count == CNT_W'(1))) begin
            state  <= FS_HALTED;
            halted <= 1'b1;
          end
        end
        FS_HALTED: begin
          state <= FS_HALTED;
        end
        default: begin
          state <= FS_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned W = INST_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc;
  logic [W-1:0]  inst;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_target = 32'd0;
  logic          dec_valid;
  logic [W-1:0]  dec_inst;
  logic [31:0]   dec_pc;
  logic          dec_ready = 1'b0;
  logic          halted;

  logic [W-1:0]  imem [64];
  logic [31:0]   sb [$];
  int            nvec = 0;
  int            nerr = 0;

  always #5 clk = ~clk;

  assign inst = imem[pc[5:0]];

  fetch_unit #(.WIDTH(W), .DEPTH(2), .RESET_PC(32'd0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .inst            (inst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec_valid       (dec_valid),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc),
    .dec_ready       (dec_ready),
    .halted          (halted)
  );

  task automatic load_prog(input int halt_at);
    for (int i = 0; i < 64; i++) begin
      if (i == halt_at)  imem[i] = {OP_HALT, (W-OP_W)'(i)};
      else if (i == 2)   imem[i] = {OP_ADD,  (W-OP_W)'(i)};
      else               imem[i] = {OP_MOV,  (W-OP_W)'(i)};
    end
  endtask

  // Holds reset for two cycles and releases it at a falling edge
  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    dec_ready = ready;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    load_prog(-1);
    @(negedge clk);
    rst_n = 1'b0;
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'd17;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b0;
    nvec++; if (pc !== 32'd0) begin nerr++; $display("FAIL reset_pc: got %h want 0", pc); end
    nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
    nvec++; if (dec_inst !== '0) begin nerr++; $display("FAIL reset_inst: got %h want 0", dec_inst); end
    nvec++; if (dec_pc !== 32'd0) begin nerr++; $display("FAIL reset_decpc: got %h want 0", dec_pc); end
    nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_straight();
    logic [31:0] exp;
    load_prog(-1);
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) sb.push_back(32'(k));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      nvec++; if (dec_valid !== 1'b1) begin nerr++; $display("FAIL straight_valid: cycle %0d got %b want 1", c, dec_valid); end
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL straight_pop: pc=%h inst=%h want pc=%h inst=%h", dec_pc, dec_inst, exp, imem[exp[5:0]]);
        end
      end
    end
    nvec++; if (sb.size() != 0) begin nerr++; $display("FAIL straight_left: %0d entries never presented, want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    load_prog(-1);
    do_reset(1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nvec++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'd0) begin
        nerr++; $display("FAIL bp_hold: cycle %0d valid=%b pc=%h want valid=1 pc=0", c, dec_valid, dec_pc);
      end
    end
    nvec++; if (pc !== 32'd2) begin nerr++; $display("FAIL bp_pc: got %h want 2", pc); end
    for (int k = 0; k < 6; k++) sb.push_back(32'(k));
    dec_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      nvec++; if (dec_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid: cycle %0d got %b want 1", c, dec_valid); end
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL bp_pop: pc=%h inst=%h want pc=%h inst=%h", dec_pc, dec_inst, exp, imem[exp[5:0]]);
        end
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    bit hit = 1'b0;
    load_prog(-1);
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) sb.push_back(32'(k));
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL redir_pre: pc=%h want %h", dec_pc, exp);
        end
        if (exp == 32'd5) begin
          hit = 1'b1;
          redirect_valid = 1'b1;
          redirect_target = 32'd0;
        end
      end
    end
    nvec++; if (!hit) begin nerr++; $display("FAIL redir_timeout: head pc 5 never reached, want reached"); end
    @(negedge clk);
    redirect_valid = 1'b0;
    nvec++; if (pc !== 32'd0) begin nerr++; $display("FAIL redir_pc: got %h want 0", pc); end
    nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL redir_bubble: got %b want 0", dec_valid); end
    for (int k = 0; k < 3; k++) sb.push_back(32'(k));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++; if (dec_valid !== 1'b1) begin nerr++; $display("FAIL redir_valid: cycle %0d got %b want 1", c, dec_valid); end
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL redir_post: pc=%h want %h", dec_pc, exp);
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp;
    bit hit = 1'b0;
    load_prog(6);
    do_reset(1'b1);
    for (int k = 0; k < 7; k++) sb.push_back(32'(k));
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL halt_seq: pc=%h inst=%h want pc=%h inst=%h", dec_pc, dec_inst, exp, imem[exp[5:0]]);
        end
        if (exp == 32'd6) begin
          hit = 1'b1;
          nvec++; if (pc !== 32'd6) begin nerr++; $display("FAIL halt_pc_hold: got %h want 6", pc); end
          nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL halt_early: got %b want 0", halted); end
        end
      end
    end
    nvec++; if (!hit) begin nerr++; $display("FAIL halt_timeout: HALT at 6 never presented, want presented"); end
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      redirect_valid = (c == 10);
      redirect_target = 32'd1;
      nvec++;
      if (halted !== 1'b1 || dec_valid !== 1'b0 || pc !== 32'd6) begin
        nerr++; $display("FAIL halt_sticky: cycle %0d halted=%b valid=%b pc=%h want 1/0/6", c, halted, dec_valid, pc);
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_halt_wait_redirect();
    logic [31:0] exp;
    bit hit = 1'b0;
    load_prog(4);
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) sb.push_back(32'(k));
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (dec_valid && dec_pc == 32'd3) begin
        hit = 1'b1;
        dec_ready = 1'b0;
      end else if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp) begin nerr++; $display("FAIL hw_seq: pc=%h want %h", dec_pc, exp); end
      end
    end
    nvec++; if (!hit) begin nerr++; $display("FAIL hw_timeout: head pc 3 never reached, want reached"); end
    @(negedge clk);
    nvec++;
    if (pc !== 32'd4 || dec_pc !== 32'd3 || dec_valid !== 1'b1) begin
      nerr++; $display("FAIL hw_stall: pc=%h dec_pc=%h valid=%b want 4/3/1", pc, dec_pc, dec_valid);
    end
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'd2;
    if (dec_valid && sb.size() != 0) begin
      exp = sb.pop_front(); nvec++;
      if (dec_pc !== exp) begin nerr++; $display("FAIL hw_pop: pc=%h want %h", dec_pc, exp); end
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    nvec++;
    if (pc !== 32'd2 || dec_valid !== 1'b0 || halted !== 1'b0) begin
      nerr++; $display("FAIL hw_flush: pc=%h valid=%b halted=%b want 2/0/0", pc, dec_valid, halted);
    end
    sb.push_back(32'd2);
    sb.push_back(32'd3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      nvec++; if (dec_valid !== 1'b1 || halted !== 1'b0) begin nerr++; $display("FAIL hw_resume: valid=%b halted=%b want 1/0", dec_valid, halted); end
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL hw_post: pc=%h want %h", dec_pc, exp);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    load_prog(-1);
    do_reset(1'b1);
    @(negedge clk);
    nvec++; if (dec_valid !== 1'b1 || dec_pc !== 32'd0) begin nerr++; $display("FAIL wrap_first: valid=%b pc=%h want 1/0", dec_valid, dec_pc); end
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    nvec++; if (pc !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL wrap_pc: got %h want ffffffff", pc); end
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'd0);
    sb.push_back(32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++; if (dec_valid !== 1'b1) begin nerr++; $display("FAIL wrap_valid: cycle %0d got %b want 1", c, dec_valid); end
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL wrap_seq: pc=%h want %h", dec_pc, exp);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] exp;
    load_prog(-1);
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    nvec++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'd0 || pc !== 32'd2) begin
      nerr++; $display("FAIL mid_full: valid=%b dec_pc=%h pc=%h want 1/0/2", dec_valid, dec_pc, pc);
    end
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'd9;
    @(negedge clk);
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    nvec++;
    if (pc !== 32'd0 || dec_valid !== 1'b0 || halted !== 1'b0) begin
      nerr++; $display("FAIL mid_reset: pc=%h valid=%b halted=%b want 0/0/0", pc, dec_valid, halted);
    end
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(32'(k));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++; if (dec_valid !== 1'b1) begin nerr++; $display("FAIL mid_valid: cycle %0d got %b want 1", c, dec_valid); end
      if (dec_valid && dec_ready && sb.size() != 0) begin
        exp = sb.pop_front(); nvec++;
        if (dec_pc !== exp || dec_inst !== imem[exp[5:0]]) begin
          nerr++; $display("FAIL mid_seq: pc=%h want %h", dec_pc, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect();
    test_halt();
    test_halt_wait_redirect();
    test_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
